coin_counter: RTL
=================

COIN_COUNTER -- requirements
Module: coin_counter

Interface
REQ-001 The block SHALL have parameter MAX_COINS, default 7: saturation/win count per player (1..7).
REQ-002 The block SHALL have parameter FLASH_CYCLES, default 25_000_000: pickup-flash duration in clocks (>=1, fits 25 bits).
REQ-003 The block SHALL have port CLK100MHZ  in  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port CPU_RESETN  in  1  reset; one clock, reset synchronous and active-low.
REQ-005 The block SHALL have port coin_p1  in  1  player-1 coin pickup, level from game logic; a 0->1 transition is one pickup.
REQ-006 The block SHALL have port coin_p2  in  1  player-2 coin pickup, same rules as coin_p1.
REQ-007 The block SHALL have port round_clr  in  1  synchronous clear of counts, flash and winner.
REQ-008 The block SHALL have port count_p1  out  3  player-1 coin count.
REQ-009 The block SHALL have port count_p2  out  3  player-2 coin count.
REQ-010 The block SHALL have port LED1  out  3  player-1 RGB code to LED stage ({R,G,B}).
REQ-011 The block SHALL have port LED2  out  3  player-2 RGB code to LED stage ({R,G,B}).
REQ-012 The block SHALL have port winner  out  2  bit0 = player 1 won, bit1 = player 2 won.

Function
REQ-013 Pickup SHALL be detected at a rising edge where coin_pX=1 and the registered previous sample of coin_pX=0; a held-high input counts once.
REQ-014 On pickup, count_pX SHALL increment by 1, visible the cycle after the detecting edge; no further latency.
REQ-015 count_pX SHALL saturate at MAX_COINS; pickups at MAX_COINS leave it unchanged and never wrap to 0.
REQ-016 Each player SHALL have an independent display FSM: SHOW (LEDx = count_pX) and FLASH (LEDx = 3'b111).
REQ-017 SHOW->FLASH SHALL occur on any accepted pickup; flash timer loads FLASH_CYCLES-1.
REQ-018 In FLASH the timer SHALL decrement each clock; FLASH->SHOW when timer = 0, so LEDx = 3'b111 for exactly FLASH_CYCLES clocks.
REQ-019 A pickup during FLASH SHALL reload the timer (retrigger) and remain in FLASH.
REQ-020 When count_pX first reaches MAX_COINS, winner bit X SHALL set on the same edge and hold until round_clr or reset.
REQ-021 Both players reaching MAX_COINS on the same edge SHALL give winner = 2'b11.
REQ-022 While winner != 0, all pickups from both players SHALL be ignored (no count change, no flash).
REQ-023 Simultaneous pickups on both players SHALL both be accepted in the same cycle.
REQ-024 round_clr SHALL zero counts, winner and timers, force SHOW, and take priority over a same-cycle pickup; the previous-sample registers keep updating.

Reset
REQ-025 With CPU_RESETN=0 at a rising edge: count_p1=count_p2=0, LED1=LED2=3'b000, winner=2'b00, both FSMs SHOW, timers 0.
REQ-026 Previous-sample registers SHALL reset to 1, so an input already high at reset release is not counted.
REQ-027 Reset asserted mid-FLASH SHALL abort the flash on that edge; reset overrides round_clr and pickups.

Configuration
REQ-028 Macro COIN_FLASH_EN defined: FLASH state, timer and REQ-016..REQ-019 SHALL be compiled in.
REQ-029 Macro COIN_FLASH_EN undefined: no timer/FSM logic; LEDx SHALL equal count_pX every cycle; FLASH_CYCLES is unused; all other requirements unchanged.

Verification (FLASH_CYCLES=4, MAX_COINS=7, COIN_FLASH_EN defined unless noted)
REQ-030 The bench SHALL check: reset, then coin_p1 pulses high 1 cycle -> count_p1=1 next cycle, LED1=3'b111 for 4 cycles, then LED1=3'b001.
REQ-031 The bench SHALL check: coin_p2 held high 20 cycles -> count_p2=1 only; second pickup at flash cycle 3 -> count_p2=2, LED2=3'b111 for 4 more cycles, then 3'b010.
REQ-032 The bench SHALL check: 7 pickups on p1 -> count_p1=7, winner=2'b01; then 3 pickups each on p1 and p2 -> counts 7/0, LED unchanged, winner=2'b01.
REQ-033 The bench SHALL check: both at 6, simultaneous pickups -> counts 7/7, winner=2'b11; round_clr with coincident coin_p1 rise -> counts 0/0, winner=0, LEDs 3'b000.
REQ-034 The bench SHALL check: coin_p1 high during and after reset release -> count_p1 stays 0; reset at flash cycle 2 -> LED1=3'b000 on next cycle.
REQ-035 The bench SHALL check with COIN_FLASH_EN undefined: 3 pickups on p1 -> LED1 tracks count_p1 each cycle (001,010,011), never 3'b111.

Source files
------------

// File: rtl/coin_counter.sv
// Two-player coin pickup counter with saturation, win detection and per-player LED codes.
// Define COIN_FLASH_EN to add the per-player pickup flash; without it the LEDs show the counts.
module coin_counter #(
    parameter int MAX_COINS    = 7,
    parameter int FLASH_CYCLES = 25_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       coin_p1,
    input  logic       coin_p2,
    input  logic       round_clr,
    output logic [2:0] count_p1,
    output logic [2:0] count_p2,
    output logic [2:0] LED1,
    output logic [2:0] LED2,
    output logic [1:0] winner
);

    localparam logic [2:0] MAX_CNT   = 3'(MAX_COINS);
    localparam logic [2:0] LAST_STEP = 3'(MAX_COINS - 1);

    logic [1:0] w_coin;
    logic [1:0] r_prev;
    logic [1:0] w_acc;
    logic [1:0] r_winner;
    logic [2:0] r_count [2];

    assign w_coin = {coin_p2, coin_p1};
    // Pickups are dropped entirely once the round has a winner.
    assign w_acc  = w_coin & ~r_prev & {2{r_winner == 2'b00}};

    // Resetting to 1 keeps a coin input already high at reset release from counting.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            r_prev <= 2'b11;
        end else begin
            r_prev <= w_coin;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!CPU_RESETN || round_clr) begin
            r_winner <= 2'b00;
            for (int i = 0; i < 2; i++) r_count[i] <= 3'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_acc[i] && (r_count[i] != MAX_CNT)) begin
                    r_count[i] <= r_count[i] + 3'd1;
                    if (r_count[i] == LAST_STEP) r_winner[i] <= 1'b1;
                end
            end
        end
    end

    assign count_p1 = r_count[0];
    assign count_p2 = r_count[1];
    assign winner   = r_winner;

`ifdef COIN_FLASH_EN
    typedef enum logic {SHOW, FLASH} state_t;

    localparam logic [24:0] FLASH_LOAD = 25'(FLASH_CYCLES - 1);

    state_t      r_state     [2];
    state_t      w_state_nxt [2];
    logic [24:0] r_timer     [2];
    logic [24:0] w_timer_nxt [2];

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= SHOW;
                r_timer[i] <= 25'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
        end
    end

    // A pickup (re)loads the timer from either state; FLASH ends on the clock the timer is 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: defaults first so no path leaves a next-state value unassigned (no latches).
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            if (round_clr) begin
                w_state_nxt[i] = SHOW;
                w_timer_nxt[i] = 25'd0;
            end else if (w_acc[i]) begin
                w_state_nxt[i] = FLASH;
                w_timer_nxt[i] = FLASH_LOAD;
            end else if (r_state[i] == FLASH) begin
                if (r_timer[i] == 25'd0) begin
                    w_state_nxt[i] = SHOW;
                end else begin
                    w_timer_nxt[i] = r_timer[i] - 25'd1;
                end
            end
        end
    end

    assign LED1 = (r_state[0] == FLASH) ? 3'b111 : r_count[0];
    assign LED2 = (r_state[1] == FLASH) ? 3'b111 : r_count[1];
`else
    logic [24:0] w_unused_flash;

    assign w_unused_flash = 25'(FLASH_CYCLES - 1);
    assign LED1 = r_count[0];
    assign LED2 = r_count[1];
`endif

endmodule
